// File: rtl/id_decode_if.sv
// ---------------------------------------------------------------------------
// id_decode_if
// Bundles every signal the decode stage exchanges with its neighbours:
//   fetch side     : id_instr, id_pc in; Stall, Loop, PC_in out
//   execute side   : ex_stall in; ex_valid, ex_op, ex_rd, ex_we, ex_a,
//                    ex_b, ex_pc out
//   writeback side : wb_en, wb_addr, wb_data in
// The slave modport is the decoder's view; master is the surrounding
// pipeline (or a testbench) driving it.
// ---------------------------------------------------------------------------
interface id_decode_if #(
   parameter int DW = 32,
   parameter int AW = 16
);
   logic [31:0]   id_instr;
   logic [AW-1:0] id_pc;
   logic          Stall;
   logic          Loop;
   logic [AW-1:0] PC_in;
   logic          ex_stall;
   logic          ex_valid;
   logic [5:0]    ex_op;
   logic [3:0]    ex_rd;
   logic          ex_we;
   logic [DW-1:0] ex_a;
   logic [DW-1:0] ex_b;
   logic [AW-1:0] ex_pc;
   logic          wb_en;
   logic [3:0]    wb_addr;
   logic [DW-1:0] wb_data;

   modport slave (
      input  id_instr, id_pc, ex_stall, wb_en, wb_addr, wb_data,
      output Stall, Loop, PC_in, ex_valid, ex_op, ex_rd, ex_we, ex_a, ex_b, ex_pc
   );

   modport master (
      output id_instr, id_pc, ex_stall, wb_en, wb_addr, wb_data,
      input  Stall, Loop, PC_in, ex_valid, ex_op, ex_rd, ex_we, ex_a, ex_b, ex_pc
   );
endinterface

// File: rtl/id_decode.sv
// ---------------------------------------------------------------------------
// id_decode
// Instruction-decode stage. Decodes the fetched instruction, reads the
// register file, tracks in-flight writes with a one-bit-per-register
// scoreboard, raises Stall towards fetch and Loop/PC_in for hardware
// loops, and registers a decoded bundle for execute.
// Ports:
//   CLOCK_50 : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : id_decode_if.slave (fetch, execute and writeback signals)
// Optional feature: define ID_BYPASS_EN to forward writeback data straight
// into the operand read so that a dependent instruction issues in the same
// cycle its producer writes back. Without it, operands come from the
// register file only.
// ---------------------------------------------------------------------------
module id_decode #(
   parameter int DW    = 32,
   parameter int AW    = 16,
   parameter int NREGS = 16
) (
   input logic        CLOCK_50,
   input logic        reset_n,
   id_decode_if.slave bus
);

   logic [5:0]       op;
   logic [3:0]       rd, rs, rt;
   logic [15:0]      imm;
   logic             writesRd, usesRs, usesRt, isLoop, isLoopSet, passOp;
   logic [DW-1:0]    rsVal, rtVal;
   logic             rsBusy, rtBusy, hazard, stall, issue, loopTaken;

   logic [DW-1:0]    regFile_q [NREGS];
   logic [NREGS-1:0] pending_q, pending_d;
   logic [15:0]      lcnt_q, lcnt_d;
   logic             squash_q, squash_d;
   logic             exValid_q, exValid_d;
   logic [5:0]       exOp_q, exOp_d;
   logic [3:0]       exRd_q, exRd_d;
   logic             exWe_q, exWe_d;
   logic [DW-1:0]    exA_q, exA_d;
   logic [DW-1:0]    exB_q, exB_d;
   logic [AW-1:0]    exPc_q, exPc_d;

   assign op  = bus.id_instr[31:26];
   assign rd  = bus.id_instr[25:22];
   assign rs  = bus.id_instr[21:18];
   assign rt  = bus.id_instr[17:14];
   assign imm = bus.id_instr[15:0];

   // Classify the opcode. Only ALU, ADDI, LD and ST reach execute with their
   // own opcode; loop control and unknown opcodes travel as NOPs.
   always_comb begin
      writesRd  = 1'b0;
      usesRs    = 1'b0;
      usesRt    = 1'b0;
      isLoop    = 1'b0;
      isLoopSet = 1'b0;
      case (op) inside
         [6'h01:6'h0F]: begin writesRd = 1'b1; usesRs = 1'b1; usesRt = 1'b1; end
         6'h10, 6'h11:  begin writesRd = 1'b1; usesRs = 1'b1; end
         6'h12:         begin usesRs = 1'b1; usesRt = 1'b1; end
         6'h20:         isLoopSet = 1'b1;
         6'h21:         isLoop = 1'b1;
         default:       ;
      endcase
      passOp = writesRd | (op == 6'h12);
   end

   // Operand read and per-source busy check. r0 is hardwired to zero and is
   // never marked pending. With forwarding enabled, a source being written
   // back this cycle takes wb_data and no longer counts as pending.
   always_comb begin
      rsVal  = (rs == 4'd0) ? '0 : regFile_q[rs];
      rtVal  = (rt == 4'd0) ? '0 : regFile_q[rt];
      rsBusy = usesRs & pending_q[rs];
      rtBusy = usesRt & pending_q[rt];
`ifdef ID_BYPASS_EN
      if (bus.wb_en && (bus.wb_addr == rs) && (rs != 4'd0)) begin
         rsVal  = bus.wb_data;
         rsBusy = 1'b0;
      end
      if (bus.wb_en && (bus.wb_addr == rt) && (rt != 4'd0)) begin
         rtVal  = bus.wb_data;
         rtBusy = 1'b0;
      end
`endif
   end

   // Loop control waits for the whole scoreboard to drain so that the loop
   // counter is never updated while older writes are still in flight. The
   // instruction in a squash slot is thrown away, so it can never hazard.
   assign hazard    = ~squash_q & (rsBusy | rtBusy | ((isLoop | isLoopSet) & (|pending_q)));
   assign stall     = hazard | bus.ex_stall;
   assign issue     = ~stall & ~squash_q;
   assign loopTaken = issue & isLoop & (lcnt_q > 16'd1);

   assign bus.Stall = stall;
   assign bus.Loop  = loopTaken;
   assign bus.PC_in = AW'(imm);

   // Next-state for scoreboard, loop counter, squash flag and the bundle.
   // A writeback clears its bit before an issuing writer sets one, so the
   // set wins when both name the same register. With ex_stall the bundle
   // holds; a hazard or squash slot sends a bubble instead.
   always_comb begin
      pending_d = pending_q;
      lcnt_d    = lcnt_q;
      squash_d  = squash_q;
      exValid_d = exValid_q;
      exOp_d    = exOp_q;
      exRd_d    = exRd_q;
      exWe_d    = exWe_q;
      exA_d     = exA_q;
      exB_d     = exB_q;
      exPc_d    = exPc_q;

      if (bus.wb_en) pending_d[bus.wb_addr] = 1'b0;
      if (issue && writesRd && (rd != 4'd0)) pending_d[rd] = 1'b1;

      if (issue && isLoopSet) lcnt_d = imm;
      if (issue && isLoop)    lcnt_d = (lcnt_q > 16'd1) ? lcnt_q - 16'd1 : 16'd0;

      if (loopTaken)   squash_d = 1'b1;
      else if (!stall) squash_d = 1'b0;

      if (!bus.ex_stall) begin
         exValid_d = issue;
         if (issue) begin
            exOp_d = passOp ? op : 6'h00;
            exRd_d = rd;
            exWe_d = writesRd & (rd != 4'd0);
            exA_d  = rsVal;
            exB_d  = usesRt ? rtVal : DW'(imm);
            exPc_d = bus.id_pc;
         end
      end
   end

   // Register file: written by writeback on the clock edge, r0 ignored.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) regFile_q[i] <= '0;
      end else if (bus.wb_en && (bus.wb_addr != 4'd0)) begin
         regFile_q[bus.wb_addr] <= bus.wb_data;
      end
   end

   // Control state and the execute bundle, all cleared by reset.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         pending_q <= '0;
         lcnt_q    <= '0;
         squash_q  <= 1'b0;
         exValid_q <= 1'b0;
         exOp_q    <= '0;
         exRd_q    <= '0;
         exWe_q    <= 1'b0;
         exA_q     <= '0;
         exB_q     <= '0;
         exPc_q    <= '0;
      end else begin
         pending_q <= pending_d;
         lcnt_q    <= lcnt_d;
         squash_q  <= squash_d;
         exValid_q <= exValid_d;
         exOp_q    <= exOp_d;
         exRd_q    <= exRd_d;
         exWe_q    <= exWe_d;
         exA_q     <= exA_d;
         exB_q     <= exB_d;
         exPc_q    <= exPc_d;
      end
   end

   assign bus.ex_valid = exValid_q;
   assign bus.ex_op    = exOp_q;
   assign bus.ex_rd    = exRd_q;
   assign bus.ex_we    = exWe_q;
   assign bus.ex_a     = exA_q;
   assign bus.ex_b     = exB_q;
   assign bus.ex_pc    = exPc_q;

endmodule

// File: tb/tb_id_decode.sv
// ---------------------------------------------------------------------------
// tb_id_decode
// Self-checking bench for id_decode. A behavioural model (register array,
// pending flags, loop count, squash flag) predicts Stall/Loop/PC_in and the
// execute bundle for every cycle; directed scenarios add hand-derived checks.
// ---------------------------------------------------------------------------
module tb_id_decode;
   localparam int DW = 32;
   localparam int AW = 16;

   logic CLOCK_50 = 1'b0;
   logic reset_n  = 1'b0;

   id_decode_if #(.DW(DW), .AW(AW)) bus ();

   id_decode #(.DW(DW), .AW(AW), .NREGS(16)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   // 50 MHz-style free-running clock
   always #5 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mReg [16];
   bit            mPend [16];
   int unsigned   mLcnt;
   bit            mSquash;
   logic          eValid, eWe;
   logic [5:0]    eOp;
   logic [3:0]    eRd;
   logic [DW-1:0] eA, eB;
   logic [AW-1:0] ePc;
   bit            eFull;
   bit            pStall, pLoop, pIssue;
   logic [AW-1:0] expPcIn;
   logic          obsStall, obsLoop;
   logic [AW-1:0] obsPcIn;
   logic [AW+1:0] obsComb, expComb;
   logic [91:0]   obsBundle, expBundle;
   int            wbQ [$];

   // Model helper: does writeback forwarding cover source r this cycle
   function automatic bit bypassHit(input logic [3:0] r);
`ifdef ID_BYPASS_EN
      return (r != 4'd0) && bus.wb_en && (bus.wb_addr == r);
`else
      return (r != r);
`endif
   endfunction

   function automatic logic [DW-1:0] srcVal(input logic [3:0] r);
      if (r == 4'd0) return '0;
      if (bypassHit(r)) return bus.wb_data;
      return mReg[r];
   endfunction

   function automatic bit srcBusy(input logic [3:0] r);
      return (r != 4'd0) && mPend[r] && !bypassHit(r);
   endfunction

   // Clears the model to its post-reset state
   task automatic modelClear();
      foreach (mReg[i]) mReg[i] = '0;
      foreach (mPend[i]) mPend[i] = 1'b0;
      mLcnt = 0; mSquash = 1'b0;
      eValid = 1'b0; eWe = 1'b0; eOp = '0; eRd = '0; eA = '0; eB = '0; ePc = '0;
      eFull = 1'b1;
      wbQ.delete();
   endtask

   task automatic applyStimulus(input logic [31:0] ins, input logic [AW-1:0] pc, input bit exs,
                                input bit wbe, input logic [3:0] wba, input logic [DW-1:0] wbd);
      bus.id_instr = ins; bus.id_pc = pc; bus.ex_stall = exs;
      bus.wb_en = wbe; bus.wb_addr = wba; bus.wb_data = wbd;
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      applyStimulus('0, '0, 1'b0, 1'b0, '0, '0);
      modelClear();
      @(posedge CLOCK_50); #1;
      reset_n = 1'b1;
   endtask

   // Drives one cycle, samples the combinational outputs mid-cycle, advances
   // the model across the edge and captures observed/expected vectors.
   task automatic runCycle(input logic [31:0] ins, input logic [AW-1:0] pc, input bit exs,
                           input bit wbe, input logic [3:0] wba, input logic [DW-1:0] wbd);
      int op;
      logic [3:0] rd, rs, rt;
      logic [15:0] imm;
      bit wr, useS, useT, anyPend, hz;
      applyStimulus(ins, pc, exs, wbe, wba, wbd);
      #2;
      op = int'(ins[31:26]); rd = ins[25:22]; rs = ins[21:18]; rt = ins[17:14]; imm = ins[15:0];
      wr   = (op >= 1) && (op <= 17);
      useS = (op >= 1) && (op <= 18);
      useT = ((op >= 1) && (op <= 15)) || (op == 18);
      anyPend = 1'b0;
      foreach (mPend[i]) anyPend |= mPend[i];
      hz = 1'b0;
      if (!mSquash)
         hz = (useS && srcBusy(rs)) || (useT && srcBusy(rt)) || (((op == 32) || (op == 33)) && anyPend);
      pStall  = hz || exs;
      pIssue  = !pStall && !mSquash;
      pLoop   = pIssue && (op == 33) && (mLcnt > 1);
      expPcIn = imm;
      obsStall = bus.Stall; obsLoop = bus.Loop; obsPcIn = bus.PC_in;
      obsComb = {obsStall, obsLoop, pLoop ? obsPcIn : 16'h0};
      expComb = {pStall, pLoop, pLoop ? expPcIn : 16'h0};
      if (!exs) begin
         eValid = pIssue;
         if (pIssue) begin
            eFull = useS;
            eOp   = useS ? 6'(op) : 6'd0;
            eRd   = rd;
            eWe   = wr && (rd != 4'd0);
            eA    = srcVal(rs);
            eB    = useT ? srcVal(rt) : DW'(imm);
            ePc   = pc;
         end
      end
      if (wbe) begin
         mPend[wba] = 1'b0;
         if (wba != 4'd0) mReg[wba] = wbd;
      end
      if (pIssue && wr && (rd != 4'd0)) begin
         mPend[rd] = 1'b1;
         wbQ.push_back(int'(rd));
      end
      if (pIssue && (op == 32)) mLcnt = 32'(imm);
      if (pIssue && (op == 33)) mLcnt = (mLcnt > 1) ? mLcnt - 1 : 0;
      mSquash = pLoop ? 1'b1 : (pStall ? mSquash : 1'b0);
      @(posedge CLOCK_50); #1;
      obsBundle = {bus.ex_valid, bus.ex_op, bus.ex_we, bus.ex_pc, bus.ex_rd, bus.ex_a, bus.ex_b};
      expBundle = {eValid, eOp, eWe, ePc, eRd, eA, eB};
      if (!eFull) begin
         obsBundle[67:0] = '0;
         expBundle[67:0] = '0;
      end
   endtask

   function automatic logic [31:0] genInstr();
      logic [31:0] w;
      int sel;
      w = $urandom;
      w[25] = 1'b0; w[21] = 1'b0; w[17] = 1'b0;
      sel = $urandom_range(0, 9);
      case (sel)
         0:       w[31:26] = 6'h00;
         1, 2, 3: w[31:26] = 6'($urandom_range(1, 15));
         4:       w[31:26] = 6'h10;
         5:       w[31:26] = 6'h11;
         6:       w[31:26] = 6'h12;
         7:       begin w[31:26] = 6'h20; w[15:0] = 16'($urandom_range(0, 3)); end
         8:       w[31:26] = 6'h21;
         default: w[31:26] = 6'($urandom_range(19, 31));
      endcase
      return w;
   endfunction

   task automatic test_reset();
      doReset();
      #1;
      checks++;
      if ({bus.Stall, bus.Loop} !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_comb got %b want 00", {bus.Stall, bus.Loop});
      end
      checks++;
      if ({bus.ex_valid, bus.ex_op, bus.ex_we, bus.ex_pc, bus.ex_rd, bus.ex_a, bus.ex_b} !== 92'd0) begin
         errors++; $display("[TB] FAIL reset_bundle got nonzero ex_valid=%b ex_a=%h", bus.ex_valid, bus.ex_a);
      end
   endtask

   task automatic test_raw_hazard();
      logic [31:0] addi, rtype;
      int issueAt, expAt;
      doReset();
      addi  = {6'h10, 4'd1, 4'd0, 18'd5};
      rtype = {6'h01, 4'd2, 4'd1, 4'd1, 14'd0};
`ifdef ID_BYPASS_EN
      expAt = 3;
`else
      expAt = 4;
`endif
      runCycle(addi, 16'h0000, 1'b0, 1'b0, 4'd0, '0);
      checks++;
      if (obsBundle !== expBundle) begin errors++; $display("[TB] FAIL raw_addi got %h want %h", obsBundle, expBundle); end
      issueAt = -1;
      for (int c = 1; c <= 8 && issueAt < 0; c++) begin
         runCycle(rtype, 16'h0004, 1'b0, c == 3, 4'd1, 32'd5);
         checks++;
         if (obsComb !== expComb) begin errors++; $display("[TB] FAIL raw_comb c%0d got %h want %h", c, obsComb, expComb); end
         checks++;
         if (obsBundle !== expBundle) begin errors++; $display("[TB] FAIL raw_bundle c%0d got %h want %h", c, obsBundle, expBundle); end
         if (obsStall === 1'b0) issueAt = c;
      end
      checks++;
      if (issueAt != expAt) begin errors++; $display("[TB] FAIL raw_latency got %0d want %0d", issueAt, expAt); end
      checks++;
      if ({bus.ex_valid, bus.ex_a, bus.ex_b} !== {1'b1, 32'd5, 32'd5}) begin
         errors++; $display("[TB] FAIL raw_operands got v=%b a=%0d b=%0d want v=1 a=5 b=5", bus.ex_valid, bus.ex_a, bus.ex_b);
      end
   endtask

   task automatic test_loop();
      logic [31:0] loopSet, loopIns, victim, follow;
      bit taken;
      doReset();
      loopSet = {6'h20, 10'd0, 16'd3};
      loopIns = {6'h21, 10'd0, 16'h0004};
      victim  = {6'h10, 4'd5, 4'd0, 18'd1};
      follow  = {6'h01, 4'd6, 4'd5, 4'd5, 14'd0};
      runCycle(loopSet, 16'h0000, 1'b0, 1'b0, 4'd0, '0);
      checks++;
      if (obsComb !== expComb) begin errors++; $display("[TB] FAIL loopset_comb got %h want %h", obsComb, expComb); end
      for (int k = 0; k < 3; k++) begin
         taken = (k < 2);
         runCycle(loopIns, 16'h0008, 1'b0, 1'b0, 4'd0, '0);
         checks++;
         if ({obsStall, obsLoop} !== {1'b0, taken} || (taken && obsPcIn !== 16'h0004)) begin
            errors++; $display("[TB] FAIL loop_redirect k%0d got stall=%b loop=%b pc_in=%h want loop=%b pc_in=0004", k, obsStall, obsLoop, obsPcIn, taken);
         end
         checks++;
         if ({bus.ex_valid, bus.ex_we} !== 2'b10 || obsBundle !== expBundle) begin
            errors++; $display("[TB] FAIL loop_bundle k%0d got %h want %h", k, obsBundle, expBundle);
         end
         if (taken) begin
            runCycle(victim, 16'h000C, 1'b0, 1'b0, 4'd0, '0);
            checks++;
            if (bus.ex_valid !== 1'b0 || obsStall !== 1'b0) begin
               errors++; $display("[TB] FAIL loop_squash k%0d got ex_valid=%b stall=%b want 0 0", k, bus.ex_valid, obsStall);
            end
         end
      end
      runCycle(follow, 16'h000C, 1'b0, 1'b0, 4'd0, '0);
      checks++;
      if (obsStall !== 1'b0 || bus.ex_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL loop_after got stall=%b ex_valid=%b want 0 1", obsStall, bus.ex_valid);
      end
   endtask

   task automatic test_ex_stall();
      logic [91:0] held;
      doReset();
      runCycle({6'h10, 4'd2, 4'd0, 18'd9}, 16'h0010, 1'b0, 1'b0, 4'd0, '0);
      held = obsBundle;
      checks++;
      if (held !== {1'b1, 6'h10, 1'b1, 16'h0010, 4'd2, 32'd0, 32'd9}) begin
         errors++; $display("[TB] FAIL exstall_issue got %h", held);
      end
      for (int c = 0; c < 4; c++) begin
         runCycle({6'h10, 4'd7, 4'd0, 18'd1}, 16'h0014, 1'b1, 1'b0, 4'd0, '0);
         checks++;
         if (obsStall !== 1'b1 || obsBundle !== held) begin
            errors++; $display("[TB] FAIL exstall_hold c%0d got stall=%b bundle=%h want 1 %h", c, obsStall, obsBundle, held);
         end
      end
      runCycle({6'h01, 4'd8, 4'd7, 4'd7, 14'd0}, 16'h0018, 1'b0, 1'b0, 4'd0, '0);
      checks++;
      if (obsStall !== 1'b0 || obsBundle !== expBundle) begin
         errors++; $display("[TB] FAIL exstall_release got stall=%b bundle=%h want 0 %h", obsStall, obsBundle, expBundle);
      end
   endtask

   task automatic test_r0_write();
      doReset();
      runCycle({6'h10, 4'd0, 4'd0, 18'd7}, 16'h0020, 1'b0, 1'b0, 4'd0, '0);
      checks++;
      if ({bus.ex_valid, bus.ex_we} !== 2'b10) begin
         errors++; $display("[TB] FAIL r0_we got v=%b we=%b want 1 0", bus.ex_valid, bus.ex_we);
      end
      runCycle({6'h01, 4'd5, 4'd0, 4'd0, 14'd0}, 16'h0024, 1'b0, 1'b0, 4'd0, '0);
      checks++;
      if ({obsStall, bus.ex_valid, bus.ex_a, bus.ex_b} !== {1'b0, 1'b1, 64'd0}) begin
         errors++; $display("[TB] FAIL r0_read got stall=%b v=%b a=%h b=%h want 0 1 0 0", obsStall, bus.ex_valid, bus.ex_a, bus.ex_b);
      end
   endtask

   task automatic test_set_wins();
      doReset();
      runCycle({6'h10, 4'd3, 4'd0, 18'd1}, 16'h0030, 1'b0, 1'b0, 4'd0, '0);
      runCycle({6'h10, 4'd3, 4'd0, 18'd2}, 16'h0034, 1'b0, 1'b1, 4'd3, 32'h55);
      checks++;
      if (obsStall !== 1'b0 || obsBundle !== expBundle) begin
         errors++; $display("[TB] FAIL setwins_issue got stall=%b bundle=%h want 0 %h", obsStall, obsBundle, expBundle);
      end
      runCycle({6'h01, 4'd4, 4'd3, 4'd3, 14'd0}, 16'h0038, 1'b0, 1'b0, 4'd0, '0);
      checks++;
      if (obsStall !== 1'b1 || bus.ex_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL setwins_pending got stall=%b ex_valid=%b want 1 0", obsStall, bus.ex_valid);
      end
   endtask

   // Random traffic: the bench acts as fetch (holds on Stall, follows Loop)
   // and as writeback (retires issued writers in random order of delay).
   task automatic test_random();
      logic [31:0] ins;
      logic [AW-1:0] pc;
      bit exs, wbe;
      logic [3:0] wba;
      int badComb, badBundle;
      doReset();
      pc = '0; ins = genInstr(); badComb = 0; badBundle = 0;
      for (int c = 0; c < 600; c++) begin
         exs = ($urandom_range(0, 6) == 0);
         wbe = 1'b0; wba = '0;
         if (wbQ.size() > 0 && $urandom_range(0, 2) == 0) begin
            wbe = 1'b1; wba = 4'(wbQ.pop_front());
         end else if ($urandom_range(0, 15) == 0) begin
            wbe = 1'b1; wba = 4'($urandom_range(0, 7));
         end
         runCycle(ins, pc, exs, wbe, wba, $urandom);
         checks++;
         if (obsComb !== expComb) begin
            errors++; badComb++;
            if (badComb <= 5) $display("[TB] FAIL rand_comb c%0d got %h want %h", c, obsComb, expComb);
         end
         checks++;
         if (obsBundle !== expBundle) begin
            errors++; badBundle++;
            if (badBundle <= 5) $display("[TB] FAIL rand_bundle c%0d got %h want %h", c, obsBundle, expBundle);
         end
         if (pLoop) begin
            pc = expPcIn; ins = genInstr();
         end else if (!pStall) begin
            pc = pc + 16'd4; ins = genInstr();
         end
      end
   endtask

   task automatic test_reset_midstream();
      doReset();
      runCycle({6'h20, 10'd0, 16'd5}, 16'h0040, 1'b0, 1'b0, 4'd0, '0);
      runCycle({6'h10, 4'd6, 4'd0, 18'd3}, 16'h0044, 1'b0, 1'b0, 4'd0, '0);
      #2;
      reset_n = 1'b0;
      applyStimulus('0, '0, 1'b0, 1'b0, '0, '0);
      #1;
      checks++;
      if ({bus.Stall, bus.Loop, bus.ex_valid, bus.ex_op, bus.ex_we, bus.ex_pc, bus.ex_rd, bus.ex_a, bus.ex_b} !== 94'd0) begin
         errors++; $display("[TB] FAIL midreset_clear got v=%b rd=%h a=%h stall=%b", bus.ex_valid, bus.ex_rd, bus.ex_a, bus.Stall);
      end
      modelClear();
      @(posedge CLOCK_50); #1;
      reset_n = 1'b1;
      runCycle({6'h21, 10'd0, 16'h0020}, 16'h0048, 1'b0, 1'b0, 4'd0, '0);
      checks++;
      if ({obsStall, obsLoop, bus.ex_valid} !== 3'b001) begin
         errors++; $display("[TB] FAIL midreset_state got stall=%b loop=%b v=%b want 0 0 1", obsStall, obsLoop, bus.ex_valid);
      end
   endtask

   initial begin
      applyStimulus('0, '0, 1'b0, 1'b0, '0, '0);
      test_reset();
      test_raw_hazard();
      test_loop();
      test_ex_stall();
      test_r0_write();
      test_set_wins();
      test_random();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
